// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave cook sequencer and its BCD timer.
package microwave_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SET   = 3'd1,
      COOK  = 3'd2,
      PAUSE = 3'd3,
      DONE  = 3'd4
   } mw_state_t;

   localparam logic [3:0] BCD_MAX_SEC_TENS = 4'd5;
   localparam logic [3:0] BCD_MAX_ONES     = 4'd9;

   function automatic logic is_valid_digit(input logic [3:0] digit);
      return digit <= BCD_MAX_ONES;
   endfunction

endpackage

// File: rtl/mw_bcd_timer.sv
// Four-digit mm:ss BCD register: clear, keypad shift-in and one-second decrement.
module mw_bcd_timer
   import microwave_pkg::*;
(
   input  logic       clk,
   input  logic       rstn,
   input  logic       clear,
   input  logic       shift_en,
   input  logic [3:0] shift_digit,
   input  logic       dec_en,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       is_zero,
   output logic       is_one
);

   assign is_zero = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                    (sec_tens == 4'd0) && (sec_ones == 4'd0);
   assign is_one  = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                    (sec_tens == 4'd0) && (sec_ones == 4'd1);

   // Borrow ripples left; sec_tens above 5 simply counts down as plain BCD.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         min_tens <= 4'd0;
         min_ones <= 4'd0;
         sec_tens <= 4'd0;
         sec_ones <= 4'd0;
      end else if (clear) begin
         min_tens <= 4'd0;
         min_ones <= 4'd0;
         sec_tens <= 4'd0;
         sec_ones <= 4'd0;
      end else if (shift_en) begin
         min_tens <= min_ones;
         min_ones <= sec_tens;
         sec_tens <= sec_ones;
         sec_ones <= shift_digit;
      end else if (dec_en) begin
         if (sec_ones != 4'd0) begin
            sec_ones <= sec_ones - 4'd1;
         end else begin
            sec_ones <= BCD_MAX_ONES;
            if (sec_tens != 4'd0) begin
               sec_tens <= sec_tens - 4'd1;
            end else begin
               sec_tens <= BCD_MAX_SEC_TENS;
               if (min_ones != 4'd0) begin
                  min_ones <= min_ones - 4'd1;
               end else begin
                  min_ones <= BCD_MAX_ONES;
                  min_tens <= min_tens - 4'd1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/microwave_cook_sequencer.sv
// Cook sequencer: button edge detection, state machine, tick prescaler and magnetron enable.
module microwave_cook_sequencer
   import microwave_pkg::*;
#(
   parameter int CLK_DIV = 50_000_000,
   parameter int PRESC_W = 26
)(
   input  logic       clk,
   input  logic       rstn,
   input  logic       startn,
   input  logic       stopn,
   input  logic       clearn,
   input  logic       door_closed,
   input  logic       key_valid,
   input  logic [3:0] key_digit,
   output logic       mag_on,
   output logic       timer_done,
   output logic       done_flag,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic [2:0] state
);

   mw_state_t          state_q, next_state;
   logic [PRESC_W-1:0] presc, presc_next;
   logic               start_q, stop_q, clear_q, door_q;
   logic               start_press, stop_press, clear_press, door_fall;
   logic               tm_clear, tm_shift, tm_dec, done_pulse;
   logic               key_ok, shifted_nz, tick, is_zero, is_one;

   assign start_press = start_q & ~startn;
   assign stop_press  = stop_q  & ~stopn;
   assign clear_press = clear_q & ~clearn;
   assign door_fall   = door_q  & ~door_closed;
   assign key_ok      = key_valid && is_valid_digit(key_digit);
   assign shifted_nz  = (min_ones | sec_tens | sec_ones | key_digit) != 4'd0;
   assign tick        = (presc == PRESC_W'(CLK_DIV - 1));
   assign state       = state_q;

   mw_bcd_timer u_timer (
      .clk         (clk),
      .rstn        (rstn),
      .clear       (tm_clear),
      .shift_en    (tm_shift),
      .shift_digit (key_digit),
      .dec_en      (tm_dec),
      .min_tens    (min_tens),
      .min_ones    (min_ones),
      .sec_tens    (sec_tens),
      .sec_ones    (sec_ones),
      .is_zero     (is_zero),
      .is_one      (is_one)
   );

   // Event priority: clear, then door open, stop, start, key.
   always_comb begin
      next_state = state_q;
      presc_next = presc;
      tm_clear   = 1'b0;
      tm_shift   = 1'b0;
      tm_dec     = 1'b0;
      done_pulse = 1'b0;
      if (clear_press) begin
         next_state = IDLE;
         presc_next = '0;
         tm_clear   = 1'b1;
      end else begin
         case (state_q)
            IDLE, SET: begin
               if (state_q == SET && stop_press) begin
                  next_state = IDLE;
                  presc_next = '0;
                  tm_clear   = 1'b1;
               end else if (state_q == SET && start_press && door_closed && !is_zero) begin
                  next_state = COOK;
                  presc_next = '0;
               end else if (key_ok) begin
                  tm_shift   = 1'b1;
                  next_state = shifted_nz ? SET : IDLE;
               end
            end
            COOK: begin
               if (!door_closed || stop_press) begin
                  next_state = PAUSE;
               end else if (tick) begin
                  presc_next = '0;
                  tm_dec     = 1'b1;
                  if (is_one) begin
                     next_state = DONE;
                     done_pulse = 1'b1;
                  end
               end else begin
                  presc_next = presc + PRESC_W'(1);
               end
            end
            PAUSE: begin
               if (stop_press) begin
                  next_state = IDLE;
                  presc_next = '0;
                  tm_clear   = 1'b1;
               end else if (start_press && door_closed) begin
                  next_state = COOK;
               end
            end
            DONE: begin
               if (door_fall) begin
                  next_state = IDLE;
                  presc_next = '0;
                  tm_clear   = 1'b1;
               end
            end
            default: begin
               next_state = IDLE;
               presc_next = '0;
               tm_clear   = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         presc      <= '0;
         mag_on     <= 1'b0;
         timer_done <= 1'b0;
         done_flag  <= 1'b0;
         start_q    <= 1'b1;
         stop_q     <= 1'b1;
         clear_q    <= 1'b1;
         door_q     <= 1'b1;
      end else begin
         state_q    <= next_state;
         presc      <= presc_next;
         mag_on     <= (next_state == COOK) && door_closed;
         timer_done <= done_pulse;
         done_flag  <= (next_state == DONE);
         start_q    <= startn;
         stop_q     <= stopn;
         clear_q    <= clearn;
         door_q     <= door_closed;
      end
   end

endmodule

// File: tb/tb_microwave_cook_sequencer.sv
// Self-checking bench for the cook sequencer with a seconds-level countdown model.
module tb_microwave_cook_sequencer;

   localparam int CLK_DIV = 4;
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SET   = 3'd1;
   localparam logic [2:0] ST_COOK  = 3'd2;
   localparam logic [2:0] ST_PAUSE = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   logic        clk = 1'b0;
   logic        rstn, startn, stopn, clearn, door_closed, key_valid;
   logic [3:0]  key_digit;
   logic        mag_on, timer_done, done_flag;
   logic [3:0]  min_tens, min_ones, sec_tens, sec_ones;
   logic [2:0]  state;
   logic [15:0] disp;
   int          checks = 0;
   int          errors = 0;

   assign disp = {min_tens, min_ones, sec_tens, sec_ones};

   microwave_cook_sequencer #(.CLK_DIV(CLK_DIV), .PRESC_W(3)) dut (
      .clk(clk), .rstn(rstn), .startn(startn), .stopn(stopn), .clearn(clearn),
      .door_closed(door_closed), .key_valid(key_valid), .key_digit(key_digit),
      .mag_on(mag_on), .timer_done(timer_done), .done_flag(done_flag),
      .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
      .sec_ones(sec_ones), .state(state)
   );

   always #5 clk = ~clk;

   // Entered value is a 4-digit decimal mmss; each tick removes one second from it.
   function automatic logic [15:0] model_display(input int val, input int ticks);
      int m;
      int s;
      m = val / 100;
      s = val % 100;
      for (int i = 0; i < ticks; i++) begin
         if (s > 0) s--;
         else if (m > 0) begin m--; s = 59; end
      end
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press_key(input logic [3:0] d);
      key_valid = 1'b1; key_digit = d; step(1); key_valid = 1'b0;
   endtask

   task automatic press_start();
      startn = 1'b0; step(1); startn = 1'b1;
   endtask

   task automatic press_stop();
      stopn = 1'b0; step(1); stopn = 1'b1;
   endtask

   task automatic press_clear();
      clearn = 1'b0; step(1); clearn = 1'b1; step(1);
   endtask

   task automatic test_reset();
      rstn = 1'b0; step(3);
      checks++; if (state !== ST_IDLE) begin errors++; $display("[TB] FAIL reset_state: got %0d expected %0d", state, ST_IDLE); end
      checks++; if (disp !== 16'h0000) begin errors++; $display("[TB] FAIL reset_display: got %h expected 0000", disp); end
      checks++; if ({mag_on, timer_done, done_flag} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {mag_on, timer_done, done_flag}); end
      rstn = 1'b1; step(1);
   endtask

   task automatic test_basic_cook();
      press_clear();
      press_key(4'd3); press_key(4'd0);
      checks++; if (state !== ST_SET || disp !== model_display(30, 0)) begin errors++; $display("[TB] FAIL basic_entry: got state %0d disp %h expected %0d %h", state, disp, ST_SET, model_display(30, 0)); end
      press_start();
      checks++; if (state !== ST_COOK || mag_on !== 1'b1) begin errors++; $display("[TB] FAIL basic_start: got state %0d mag %b expected %0d 1", state, mag_on, ST_COOK); end
      step(4);
      checks++; if (disp !== model_display(30, 1)) begin errors++; $display("[TB] FAIL basic_first_tick: got %h expected %h", disp, model_display(30, 1)); end
      step(115);
      checks++; if (disp !== model_display(30, 29) || timer_done !== 1'b0 || state !== ST_COOK) begin errors++; $display("[TB] FAIL basic_last_second: got %h done %b state %0d expected %h 0 %0d", disp, timer_done, state, model_display(30, 29), ST_COOK); end
      step(1);
      checks++; if (timer_done !== 1'b1 || done_flag !== 1'b1 || mag_on !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_flags: got td %b df %b mag %b expected 1 1 0", timer_done, done_flag, mag_on); end
      checks++; if (state !== ST_DONE || disp !== 16'h0000) begin errors++; $display("[TB] FAIL basic_done_state: got %0d %h expected %0d 0000", state, disp, ST_DONE); end
      step(1);
      checks++; if (timer_done !== 1'b0 || done_flag !== 1'b1) begin errors++; $display("[TB] FAIL basic_pulse_width: got td %b df %b expected 0 1", timer_done, done_flag); end
      door_closed = 1'b0; step(1);
      checks++; if (state !== ST_IDLE || done_flag !== 1'b0) begin errors++; $display("[TB] FAIL done_door_exit: got %0d df %b expected %0d 0", state, done_flag, ST_IDLE); end
      door_closed = 1'b1; step(1);
   endtask

   task automatic test_minute_borrow();
      press_clear();
      press_key(4'd1); press_key(4'd0); press_key(4'd0);
      checks++; if (disp !== model_display(100, 0)) begin errors++; $display("[TB] FAIL borrow_entry: got %h expected %h", disp, model_display(100, 0)); end
      press_start(); step(4);
      checks++; if (disp !== model_display(100, 1)) begin errors++; $display("[TB] FAIL borrow_tick: got %h expected %h", disp, model_display(100, 1)); end
   endtask

   task automatic test_pause_resume();
      press_clear();
      press_key(4'd2); press_key(4'd0); press_start(); step(10);
      door_closed = 1'b0; step(1);
      checks++; if (state !== ST_PAUSE || mag_on !== 1'b0) begin errors++; $display("[TB] FAIL pause_enter: got %0d mag %b expected %0d 0", state, mag_on, ST_PAUSE); end
      step(5);
      checks++; if (disp !== model_display(20, 10 / CLK_DIV)) begin errors++; $display("[TB] FAIL pause_hold: got %h expected %h", disp, model_display(20, 10 / CLK_DIV)); end
      door_closed = 1'b1; step(1); press_start();
      checks++; if (state !== ST_COOK || mag_on !== 1'b1) begin errors++; $display("[TB] FAIL pause_resume: got %0d mag %b expected %0d 1", state, mag_on, ST_COOK); end
      step(69);
      checks++; if (state !== ST_COOK || disp !== model_display(20, 79 / CLK_DIV)) begin errors++; $display("[TB] FAIL pause_79: got %0d %h expected %0d %h", state, disp, ST_COOK, model_display(20, 79 / CLK_DIV)); end
      step(1);
      checks++; if (state !== ST_DONE || timer_done !== 1'b1) begin errors++; $display("[TB] FAIL pause_80: got %0d td %b expected %0d 1", state, timer_done, ST_DONE); end
   endtask

   task automatic test_stop_cancel();
      press_clear();
      press_key(4'd5); press_start(); step(3);
      stopn = 1'b0; step(3);
      checks++; if (state !== ST_PAUSE || mag_on !== 1'b0 || disp !== model_display(5, 0)) begin errors++; $display("[TB] FAIL stop_held: got %0d mag %b %h expected %0d 0 %h", state, mag_on, disp, ST_PAUSE, model_display(5, 0)); end
      stopn = 1'b1; step(1); press_stop();
      checks++; if (state !== ST_IDLE || disp !== 16'h0000 || mag_on !== 1'b0) begin errors++; $display("[TB] FAIL stop_cancel: got %0d %h mag %b expected %0d 0000 0", state, disp, mag_on, ST_IDLE); end
   endtask

   task automatic test_ignored_inputs();
      press_clear();
      press_key(4'd4); press_key(4'd5);
      door_closed = 1'b0; press_start();
      checks++; if (state !== ST_SET || mag_on !== 1'b0) begin errors++; $display("[TB] FAIL start_door_open: got %0d mag %b expected %0d 0", state, mag_on, ST_SET); end
      door_closed = 1'b1; step(1); press_key(4'd12);
      checks++; if (disp !== model_display(45, 0)) begin errors++; $display("[TB] FAIL bad_digit: got %h expected %h", disp, model_display(45, 0)); end
      press_start(); press_key(4'd7);
      checks++; if (disp !== model_display(45, 0) || state !== ST_COOK) begin errors++; $display("[TB] FAIL key_in_cook: got %h %0d expected %h %0d", disp, state, model_display(45, 0), ST_COOK); end
   endtask

   task automatic test_clear_priority();
      press_clear();
      press_key(4'd9); press_start(); step(2);
      startn = 1'b0; stopn = 1'b0; clearn = 1'b0; step(1);
      startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
      checks++; if (state !== ST_IDLE || disp !== 16'h0000 || mag_on !== 1'b0) begin errors++; $display("[TB] FAIL clear_wins: got %0d %h mag %b expected %0d 0000 0", state, disp, mag_on, ST_IDLE); end
      step(1);
   endtask

   task automatic test_async_reset();
      press_key(4'd8); press_start(); step(2);
      checks++; if (mag_on !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_mag: got %b expected 1", mag_on); end
      rstn = 1'b0; #2;
      checks++; if (mag_on !== 1'b0 || state !== ST_IDLE || disp !== 16'h0000) begin errors++; $display("[TB] FAIL async_reset: got mag %b %0d %h expected 0 %0d 0000", mag_on, state, disp, ST_IDLE); end
      step(1); rstn = 1'b1; step(1);
   endtask

   task automatic test_random();
      int val, nk, c, total;
      logic [3:0] d;
      for (int it = 0; it < 8; it++) begin
         press_clear();
         val = 0;
         nk = $urandom_range(1, 4);
         for (int k = 0; k < nk; k++) begin
            d = 4'($urandom_range(0, 15));
            press_key(d);
            if (d <= 4'd9) val = (val * 10 + int'(d)) % 10000;
         end
         if (val == 0) begin press_key(4'd1); val = 1; end
         checks++; if (state !== ST_SET || disp !== model_display(val, 0)) begin errors++; $display("[TB] FAIL rand_entry: got %0d %h expected %0d %h", state, disp, ST_SET, model_display(val, 0)); end
         press_start();
         total = (val / 100) * 60 + (val % 100);
         c = $urandom_range(1, 60);
         if (c >= total * CLK_DIV) c = total * CLK_DIV - 1;
         step(c);
         checks++; if (state !== ST_COOK || mag_on !== 1'b1 || disp !== model_display(val, c / CLK_DIV)) begin errors++; $display("[TB] FAIL rand_cook: val %0d clocks %0d got %0d mag %b %h expected %0d 1 %h", val, c, state, mag_on, disp, ST_COOK, model_display(val, c / CLK_DIV)); end
      end
   endtask

   initial begin
      rstn = 1'b0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
      door_closed = 1'b1; key_valid = 1'b0; key_digit = 4'd0;
      test_reset();
      test_basic_cook();
      test_minute_borrow();
      test_pause_resume();
      test_stop_cancel();
      test_ignored_inputs();
      test_clear_priority();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
